// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine for the multicycle MIPS datapath.
// Owns HI/LO; radix-2 shift-add multiply and restoring divide, WIDTH iterations each.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state   | meaning
   // S_IDLE  | waiting for start; direct HI/LO writes allowed
   // S_PREP  | take operand magnitudes, record result signs
   // S_RUN   | WIDTH shift-add / shift-subtract iterations
   // S_FIX   | apply signs, commit HI/LO, pulse done

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX
   } state_t;

   state_t               r_state;
   logic [1:0]           r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_opb;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg_res;
   logic                 r_neg_rem;
   logic                 r_zero;

   logic                 w_signed;
   logic                 w_is_div;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [WIDTH:0]       w_mul_sum;
   logic [WIDTH:0]       w_rem_sh;
   logic [WIDTH:0]       w_trial;
   logic [2*WIDTH-1:0]   w_next_acc;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;

   assign w_signed = ~r_op[0];
   assign w_is_div = r_op[1];

   assign w_mag_a = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_mag_b = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

   // Multiplier lives in the low half and shifts out; product grows into the high half.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);

   // Divide: remainder in the high half, dividend bits shift in from the low half.
   assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_trial  = w_rem_sh - {1'b0, r_opb};

   always_comb begin
      w_next_acc = r_acc;
      if (w_is_div) begin
         if (!w_trial[WIDTH]) begin
            w_next_acc = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         end else begin
            w_next_acc = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_next_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
      end
   end

   assign w_prod = r_neg_res ? -r_acc : r_acc;
   assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_opb     <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_zero    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_op     <= op;
                  r_a      <= a;
                  r_b      <= b;
                  div_zero <= 1'b0;
                  busy     <= 1'b1;
                  if (op[1] && (b == '0)) begin
                     r_zero  <= 1'b1;
                     r_state <= S_FIX;
                  end else begin
                     r_zero  <= 1'b0;
                     r_state <= S_PREP;
                  end
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            S_PREP: begin
               r_neg_res <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
               r_neg_rem <= w_signed & r_a[WIDTH-1];
               r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
               r_opb     <= w_mag_b;
               r_cnt     <= '0;
               r_state   <= S_RUN;
            end
            S_RUN: begin
               r_acc <= w_next_acc;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_ITER) r_state <= S_FIX;
            end
            S_FIX: begin
               if (r_zero) begin
                  div_zero <= 1'b1;
               end else if (w_is_div) begin
                  lo <= w_quo;
                  hi <= w_rem;
               end else begin
                  {hi, lo} <= w_prod;
               end
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
